// File: rtl/bound_flasher_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bound_flasher_pkg
// Description : Shared phase encoding, error codes and turn levels for the
//               bound flasher monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package bound_flasher_pkg;

    typedef enum logic [3:0] {
        PH_IDLE     = 4'd0,
        PH_RISE1    = 4'd1,
        PH_FALL1    = 4'd2,
        PH_RISE2    = 4'd3,
        PH_FALL2    = 4'd4,
        PH_RISE3    = 4'd5,
        PH_FALL3    = 4'd6,
        PH_FALL_END = 4'd7,
        PH_RESYNC   = 4'd8
    } phase_e;

    localparam logic [2:0] ERR_NONE        = 3'd0;
    localparam logic [2:0] ERR_BAD_CODE    = 3'd1;
    localparam logic [2:0] ERR_BAD_STEP    = 3'd2;
    localparam logic [2:0] ERR_BAD_TURN    = 3'd3;
    localparam logic [2:0] ERR_MISSED_TURN = 3'd4;

    localparam logic [4:0] PEAK1   = 5'd6;
    localparam logic [4:0] PEAK2   = 5'd11;
    localparam logic [4:0] PEAK3   = 5'd16;
    localparam logic [4:0] TROUGH5 = 5'd5;

endpackage
`default_nettype wire

// File: rtl/thermo_decoder.sv
`default_nettype none
// ============================================================================
// Module      : thermo_decoder
// Description : Counts lit LEDs and flags whether the bus is a legal
//               thermometer code (no lit LED above an unlit one).
// Revision    : 1.0 - initial release
// ============================================================================
module thermo_decoder (
    input  logic [15:0] i_therm,
    output logic [4:0]  o_level,
    output logic        o_ok
);

    always_comb begin
        o_level = '0;
        for (int k = 0; k < 16; k++) begin
            o_level = o_level + {4'd0, i_therm[k]};
        end
        o_ok = ~|(i_therm[15:1] & ~i_therm[14:0]);
    end

endmodule
`default_nettype wire

// File: rtl/bound_flasher_monitor.sv
`default_nettype none
// ============================================================================
// Module      : bound_flasher_monitor
// Description : Tracks the flasher LED level sequence, counts kickbacks,
//               pulses on a completed cycle and latches the first error.
// Revision    : 1.0 - initial release
// ============================================================================
module bound_flasher_monitor
    import bound_flasher_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] led,
    input  logic        err_clear,
    output logic [4:0]  level,
    output logic        code_ok,
    output logic [3:0]  phase,
    output logic        cycle_done,
    output logic [3:0]  kick_cnt,
    output logic        err,
    output logic [2:0]  err_code
);

    logic [15:0] r_led_q;
    logic [4:0]  r_level;
    logic        r_ok;
    phase_e      r_phase;
    logic        r_done;
    logic [3:0]  r_kick;
    logic        r_err;
    logic [2:0]  r_err_code;
    logic [4:0]  r_peak;
    logic        r_zero;

    logic [4:0]  w_lvl;
    logic        w_ok;
    phase_e      w_nxt;
    logic        w_fault;
    logic [2:0]  w_code;
    logic        w_kick;
    logic        w_done;
    logic [4:0]  w_peak_nxt;
    logic        w_zero_nxt;
    logic        w_up;
    logic        w_dn;
    logic        w_same;

    thermo_decoder u_dec (
        .i_therm (r_led_q),
        .o_level (w_lvl),
        .o_ok    (w_ok)
    );

    // w_lvl is the current sample L, r_level holds the previous sample P.
    // A reversal of direction is a turn located at P.
    always_comb begin
        w_nxt      = r_phase;
        w_fault    = 1'b0;
        w_code     = ERR_NONE;
        w_kick     = 1'b0;
        w_done     = 1'b0;
        w_peak_nxt = r_peak;
        w_zero_nxt = 1'b0;
        w_up       = (w_lvl == r_level + 5'd1);
        w_dn       = (w_lvl + 5'd1 == r_level);
        w_same     = (w_lvl == r_level);

        if (!w_ok) begin
            w_fault = 1'b1;
            w_code  = ERR_BAD_CODE;
        end else if (r_phase == PH_RESYNC) begin
            if (w_lvl == 5'd0) begin
                if (r_zero) w_nxt = PH_IDLE;
                else        w_zero_nxt = 1'b1;
            end
        end else if (!(w_up || w_dn || (w_same && r_phase == PH_IDLE))) begin
            w_fault = 1'b1;
            w_code  = ERR_BAD_STEP;
        end else begin
            case (r_phase)
                PH_IDLE: if (w_up) w_nxt = PH_RISE1;
                PH_RISE1: begin
                    if (w_up) begin
                        if (w_lvl > PEAK1) begin w_fault = 1'b1; w_code = ERR_MISSED_TURN; end
                    end else if (r_level == PEAK1) w_nxt = PH_FALL1;
                    else begin w_fault = 1'b1; w_code = ERR_BAD_TURN; end
                end
                PH_FALL1: begin
                    if (w_up) begin
                        if (r_level == 5'd0) w_nxt = PH_RISE2;
                        else begin w_fault = 1'b1; w_code = ERR_BAD_TURN; end
                    end
                end
                PH_RISE2: begin
                    if (w_up) begin
                        if (w_lvl > PEAK2) begin w_fault = 1'b1; w_code = ERR_MISSED_TURN; end
                    end else if (r_level == PEAK1 || r_level == PEAK2) begin
                        w_nxt      = PH_FALL2;
                        w_peak_nxt = r_level;
                    end else begin w_fault = 1'b1; w_code = ERR_BAD_TURN; end
                end
                PH_FALL2: begin
                    if (w_dn) begin
                        if (r_peak == PEAK2 && w_lvl < TROUGH5) begin
                            w_fault = 1'b1; w_code = ERR_MISSED_TURN;
                        end
                    end else if (r_peak == PEAK2 && r_level == TROUGH5) w_nxt = PH_RISE3;
                    else if (r_peak == PEAK1 && r_level == 5'd0) begin
                        w_kick = 1'b1;
                        w_nxt  = PH_RISE2;
                    end else begin w_fault = 1'b1; w_code = ERR_BAD_TURN; end
                end
                PH_RISE3: begin
                    if (w_dn) begin
                        if (r_level == PEAK3) w_nxt = PH_FALL_END;
                        else if (r_level == PEAK1 || r_level == PEAK2) begin
                            w_kick = 1'b1;
                            w_nxt  = PH_FALL3;
                        end else begin w_fault = 1'b1; w_code = ERR_BAD_TURN; end
                    end
                end
                PH_FALL3: begin
                    if (w_dn) begin
                        if (w_lvl < TROUGH5) begin w_fault = 1'b1; w_code = ERR_MISSED_TURN; end
                    end else if (r_level == TROUGH5) w_nxt = PH_RISE3;
                    else begin w_fault = 1'b1; w_code = ERR_BAD_TURN; end
                end
                PH_FALL_END: begin
                    if (w_dn) begin
                        if (w_lvl == 5'd0) begin
                            w_done = 1'b1;
                            w_nxt  = PH_IDLE;
                        end
                    end else begin w_fault = 1'b1; w_code = ERR_BAD_TURN; end
                end
                default: w_nxt = PH_RESYNC;
            endcase
        end

        if (w_fault) begin
            w_nxt      = PH_RESYNC;
            w_zero_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led_q    <= '0;
            r_level    <= '0;
            r_ok       <= 1'b1;
            r_phase    <= PH_IDLE;
            r_done     <= 1'b0;
            r_kick     <= '0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_peak     <= '0;
            r_zero     <= 1'b0;
        end else begin
            r_led_q <= led;
            r_level <= w_lvl;
            r_ok    <= w_ok;
            r_phase <= w_nxt;
            r_done  <= w_done;
            r_peak  <= w_peak_nxt;
            r_zero  <= w_zero_nxt;

            if (err_clear)                      r_kick <= '0;
            else if (w_kick && r_kick != 4'd15) r_kick <= r_kick + 4'd1;

            if (w_fault)        r_err <= 1'b1;
            else if (err_clear) r_err <= 1'b0;

            // A fresh error coinciding with a clear wins over the clear.
            if (w_fault && (err_clear || r_err_code == ERR_NONE)) r_err_code <= w_code;
            else if (err_clear)                                   r_err_code <= ERR_NONE;
        end
    end

    assign level      = r_level;
    assign code_ok    = r_ok;
    assign phase      = r_phase;
    assign cycle_done = r_done;
    assign kick_cnt   = r_kick;
    assign err        = r_err;
    assign err_code   = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_bound_flasher_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_bound_flasher_monitor
// Description : Randomised and directed bench with a level-sequence model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bound_flasher_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] led = '0;
    logic        err_clear = 1'b0;
    logic [4:0]  level;
    logic        code_ok;
    logic [3:0]  phase;
    logic        cycle_done;
    logic [3:0]  kick_cnt;
    logic        err;
    logic [2:0]  err_code;

    bound_flasher_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .led        (led),
        .err_clear  (err_clear),
        .level      (level),
        .code_ok    (code_ok),
        .phase      (phase),
        .cycle_done (cycle_done),
        .kick_cnt   (kick_cnt),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // reference model state
    logic [15:0] m_ledq = '0;
    int m_level = 0, m_ok = 1, m_phase = 0, m_done = 0, m_kick = 0;
    int m_err = 0, m_code = 0, m_peak = 0, m_zero = 0;

    int  cur = 0;
    bit  inj_en = 0;
    int  done_seen = 0;
    int  ph_q[$];
    int  last_ph = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] therm(input int l);
        int t;
        t = (1 << l) - 1;
        return t[15:0];
    endfunction

    // Turn at level p from state ph: returns next state or -1 if not allowed.
    function automatic int turn_dest(input int ph, input int pk, input int p, output int kick);
        kick = 0;
        case (ph)
            1: return (p == 6) ? 2 : -1;
            2: return (p == 0) ? 3 : -1;
            3: return (p == 6 || p == 11) ? 4 : -1;
            4: if (pk == 11 && p == 5) return 5;
               else if (pk == 6 && p == 0) begin kick = 1; return 3; end
               else return -1;
            5: if (p == 16) return 7;
               else if (p == 6 || p == 11) begin kick = 1; return 6; end
               else return -1;
            6: return (p == 5) ? 5 : -1;
            default: return -1;
        endcase
    endfunction

    task automatic model_edge(input logic [15:0] v, input bit clr, input bit r);
        int L, P, d, fault, code, kick, done, nph, nzero, dest, rising, ceil_l, floor_l;
        if (r) begin
            m_ledq = '0; m_level = 0; m_ok = 1; m_phase = 0; m_done = 0; m_kick = 0;
            m_err = 0; m_code = 0; m_peak = 0; m_zero = 0;
            return;
        end
        L = 0;
        for (int k = 0; k < 16; k++) L += m_ledq[k];
        P = m_level;
        fault = 0; code = 0; kick = 0; done = 0; nph = m_phase; nzero = 0;
        if (int'(m_ledq) != (1 << L) - 1) begin
            fault = 1; code = 1;
        end else if (m_phase == 8) begin
            if (L == 0) begin
                if (m_zero != 0) nph = 0; else nzero = 1;
            end
        end else begin
            d = L - P;
            rising  = (m_phase == 1 || m_phase == 3 || m_phase == 5);
            ceil_l  = (m_phase == 1) ? 6 : (m_phase == 3) ? 11 : 16;
            floor_l = (m_phase == 6 || (m_phase == 4 && m_peak == 11)) ? 5 : 0;
            if (!(d == 1 || d == -1 || (d == 0 && m_phase == 0))) begin
                fault = 1; code = 2;
            end else if (m_phase == 0) begin
                if (d == 1) nph = 1;
            end else if ((rising != 0) == (d == 1)) begin
                if (L > ceil_l || L < floor_l) begin fault = 1; code = 4; end
                else if (m_phase == 7 && L == 0) begin done = 1; nph = 0; end
            end else begin
                dest = turn_dest(m_phase, m_peak, P, kick);
                if (dest < 0) begin fault = 1; code = 3; end
                else begin
                    nph = dest;
                    if (m_phase == 3) m_peak = P;
                end
            end
        end
        if (fault != 0) begin nph = 8; nzero = 0; kick = 0; end
        if (clr) m_kick = 0;
        else if (kick != 0 && m_kick < 15) m_kick++;
        if (fault != 0 && (clr || m_code == 0)) m_code = code;
        else if (clr) m_code = 0;
        if (fault != 0) m_err = 1;
        else if (clr) m_err = 0;
        m_level = L; m_ok = (int'(m_ledq) == (1 << L) - 1) ? 1 : 0;
        m_ledq = v; m_phase = nph; m_done = done; m_zero = nzero;
    endtask

    task automatic cyc(input logic [15:0] v, input bit clr);
        led = v;
        err_clear = clr;
        @(posedge clk);
        model_edge(v, clr, rst);
        #1;
        chk("level",      level,      m_level);
        chk("code_ok",    code_ok,    m_ok);
        chk("phase",      phase,      m_phase);
        chk("cycle_done", cycle_done, m_done);
        chk("kick_cnt",   kick_cnt,   m_kick);
        chk("err",        err,        m_err);
        chk("err_code",   err_code,   m_code);
        if (int'(phase) != last_ph) begin ph_q.push_back(int'(phase)); last_ph = int'(phase); end
        if (cycle_done) done_seen++;
        err_clear = 1'b0;
    endtask

    task automatic send(input int l);
        logic [15:0] v;
        bit clr;
        v = therm(l);
        clr = 0;
        if (inj_en) begin
            if ($urandom_range(0, 39) == 0) v = 16'($urandom);
            else if ($urandom_range(0, 59) == 0) v = therm($urandom_range(0, 16));
            clr = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 299) == 0);
        end
        cyc(v, clr);
        rst = 1'b0;
    endtask

    task automatic walk_to(input int tgt);
        while (cur != tgt) begin
            cur += (tgt > cur) ? 1 : -1;
            send(cur);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cur = 0;
        cyc(16'h0, 1'b0);
        cyc(16'h0, 1'b0);
        rst = 1'b0;
        done_seen = 0;
        ph_q.delete();
        last_ph = 0;
    endtask

    task automatic walk_list(input int pts[$]);
        foreach (pts[i]) walk_to(pts[i]);
        repeat (3) send(0);
    endtask

    initial begin
        int exp_ph[$];
        int pts[$];

        do_reset();
        chk("rst_level", level, 0);
        chk("rst_code_ok", code_ok, 1);
        chk("rst_phase", phase, 0);
        chk("rst_err", err, 0);

        // full legal sequence
        walk_list('{6, 0, 11, 5, 16, 0});
        exp_ph = '{1, 2, 3, 4, 5, 7, 0};
        chk("seq_phase_count", ph_q.size(), exp_ph.size());
        foreach (exp_ph[i]) if (i < ph_q.size()) chk("seq_phase_visit", ph_q[i], exp_ph[i]);
        chk("seq_done", done_seen, 1);
        chk("seq_err", err, 0);
        chk("seq_kick", kick_cnt, 0);

        // kickback in RISE2
        do_reset();
        walk_list('{6, 0, 6, 0, 11, 5, 16, 0});
        chk("kick2_cnt", kick_cnt, 1);
        chk("kick2_done", done_seen, 1);
        chk("kick2_err", err, 0);

        // kickback in RISE3 at 11
        do_reset();
        walk_list('{6, 0, 11, 5, 11, 5, 16, 0});
        chk("kick3_cnt", kick_cnt, 1);
        chk("kick3_err", err, 0);

        // illegal thermometer code
        do_reset();
        cyc(16'h0005, 1'b0);
        cyc(16'h0000, 1'b0);
        chk("badcode_ok", code_ok, 0);
        chk("badcode_err", err, 1);
        chk("badcode_code", err_code, 1);
        chk("badcode_phase", phase, 8);
        cyc(16'h0000, 1'b0);
        cyc(16'h0000, 1'b0);
        chk("resync_phase", phase, 0);

        // bad step, then missed turn does not overwrite the first code
        do_reset();
        walk_to(3);
        cur = 5;
        send(5);
        walk_to(0);
        repeat (3) send(0);
        chk("badstep_code", err_code, 2);
        chk("badstep_phase", phase, 0);
        walk_to(7);
        walk_to(0);
        repeat (3) send(0);
        chk("missed_keep_code", err_code, 2);
        chk("missed_err", err, 1);
        // new error on the same edge as err_clear
        cyc(16'h0005, 1'b0);
        cyc(16'h0000, 1'b1);
        chk("clr_coincide_err", err, 1);
        chk("clr_coincide_code", err_code, 1);
        cyc(16'h0000, 1'b1);
        chk("clr_err", err, 0);
        chk("clr_code", err_code, 0);

        // reset mid-sequence
        do_reset();
        walk_to(6); walk_to(0); walk_to(9);
        send(9);
        rst = 1'b1;
        cyc(therm(9), 1'b0);
        rst = 1'b0;
        chk("midrst_level", level, 0);
        chk("midrst_phase", phase, 0);
        chk("midrst_kick", kick_cnt, 0);
        chk("midrst_err", err, 0);
        chk("midrst_done", done_seen, 0);
        cur = 9;
        walk_to(0);
        repeat (3) send(0);

        // kick counter saturation
        do_reset();
        walk_to(6); walk_to(0);
        repeat (17) begin walk_to(6); walk_to(0); end
        walk_to(2);
        chk("kick_sat", kick_cnt, 15);
        do_reset();

        // randomized sequences with faults, clears and resets
        inj_en = 1;
        repeat (40) begin
            pts.delete();
            pts.push_back(6); pts.push_back(0);
            repeat ($urandom_range(0, 2)) begin pts.push_back(6); pts.push_back(0); end
            pts.push_back(11); pts.push_back(5);
            repeat ($urandom_range(0, 2)) begin
                pts.push_back(($urandom_range(0, 1) != 0) ? 11 : 6);
                pts.push_back(5);
            end
            pts.push_back(16); pts.push_back(0);
            if ($urandom_range(0, 5) == 0) pts.insert(1, $urandom_range(1, 5));
            foreach (pts[i]) walk_to(pts[i]);
            repeat ($urandom_range(2, 4)) send(0);
        end
        inj_en = 0;
        rst = 1'b0;
        repeat (3) send(0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
